// File: rtl/mem_arbiter.sv
// Two-master memory arbiter (dcache = master 0, icache = master 1).
// A grant stays locked for as long as the granted master holds its enable,
// so a writeback followed by a refill reaches memory as one atomic sequence.
// Contested requests from IDLE alternate by remembering the last winner.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // index of the master granted most recently

  // State and last-winner registers; reset drops any grant immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;        // master 0 wins the first contest
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: hold while the owner keeps enable, hand over on release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_enable_i && m1_enable_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_enable_i)           state_d = GNT0;
        else if (m1_enable_i)           state_d = GNT1;
        else                            state_d = IDLE;
      end
      GNT0: begin
        if (!m0_enable_i) state_d = m1_enable_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_enable_i) state_d = m0_enable_i ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Remember the winner on every edge that lands in a grant state.
  always_comb begin
    last_d = last_q;
    if (state_d == GNT0) last_d = 1'b0;
    if (state_d == GNT1) last_d = 1'b1;
  end

  // Outputs: route the owner's request to memory and its ack back.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    grant_o      = 2'b00;
    unique case (state_q)
      GNT0: begin
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
        grant_o      = 2'b01;
      end
      GNT1: begin
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
        grant_o      = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is shared; each master qualifies it with its own ack.
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the address width of all address ports.
REQ-002 Parameter DATA_W, default 256, shall set the cache-line width of all data ports.
REQ-003 clk_i  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-004 rst_i  input  1  shall be the asynchronous, active-low reset.
REQ-005 m0_enable_i  input  1  shall be the master-0 (dcache) request, held high for the whole transaction sequence.
REQ-006 m0_write_i  input  1  shall be master-0 write (1) or read (0).
REQ-007 m0_addr_i  input  ADDR_W  shall be the master-0 line address.
REQ-008 m0_data_i  input  DATA_W  shall be the master-0 write data.
REQ-009 m0_data_o  output  DATA_W  shall be the master-0 read data.
REQ-010 m0_ack_o  output  1  shall be the master-0 acknowledge.
REQ-011 m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o shall be the master-1 (icache) ports, with the same widths and meanings as master 0.
REQ-012 mem_enable_o  output  1  shall be the data memory enable.
REQ-013 mem_write_o  output  1  shall be the data memory write.
REQ-014 mem_addr_o  output  ADDR_W  shall be the data memory address.
REQ-015 mem_data_o  output  DATA_W  shall be the data memory write data.
REQ-016 mem_data_i  input  DATA_W  shall be the data memory read data.
REQ-017 mem_ack_i  input  1  shall be the data memory acknowledge.
REQ-018 grant_o  output  2  shall be the one-hot current grant: bit0 = master 0, bit1 = master 1, 00 = idle.

Function
REQ-019 The state machine shall have three states, IDLE, GNT0 and GNT1, stored in registers.
REQ-020 IDLE, single requester: a clock edge sampling exactly one enable high shall move to that requester's GNT state.
REQ-021 IDLE, both requesters: a clock edge sampling both enables high shall grant the master that is not recorded in last_grant.
REQ-022 Grant locking: GNTx shall persist while mx_enable_i stays high, regardless of mem_ack_i or of the other master's request, so that a writeback followed by a refill stays atomic.
REQ-023 Release: at the edge where GNTx samples mx_enable_i low, the arbiter shall move to the other GNT state if the other enable is high; otherwise it shall move to IDLE.
REQ-024 last_grant shall update to x at every edge that enters GNTx.
REQ-025 In GNTx, mem_enable_o, mem_write_o, mem_addr_o and mem_data_o shall combinationally equal master x's inputs.
REQ-026 In IDLE, mem_enable_o, mem_write_o, mem_addr_o and mem_data_o shall all be 0.
REQ-027 mx_ack_o shall equal mem_ack_i AND (state == GNTx); the non-granted master's ack shall be 0.
REQ-028 m0_data_o and m1_data_o shall both equal mem_data_i, unregistered and not gated.
REQ-029 Grant latency: a request rising in cycle N shall be granted at edge N+1 when uncontested, and mem_enable_o shall be high from cycle N+1.
REQ-030 A mem_ack_i that arrives in IDLE shall be ignored and shall not be forwarded to either master.
REQ-031 If the granted master drops enable in the same cycle that mem_ack_i is high, the ack shall still be forwarded in that cycle, and the release shall occur at the next edge.
REQ-032 grant_o shall never be 11.

Reset
REQ-033 While rst_i is low, state shall be IDLE and last_grant shall be 1, so master 0 wins the first contest.
REQ-034 Consequently, while rst_i is low, all mem_* outputs, both acks and grant_o shall be 0.
REQ-035 Reset asserted mid-transaction shall abort the grant immediately, without waiting for a clock edge.
REQ-036 After reset deasserts, arbitration shall restart from IDLE.

Verification
REQ-037 Post-reset contest: m0_enable and m1_enable rise in the same cycle -> grant_o=01 next edge; mem_addr_o=m0_addr_i; m1_ack_o held 0.
REQ-038 Dirty miss atomicity: master 0 holds enable across 2 mem_ack pulses (writeback addr 0x400, then refill addr 0x800) while m1 requests -> grant_o stays 01 throughout; it switches to 10 only at the edge after m0_enable falls.
REQ-039 Round-robin: both masters continuously re-request 4 times -> grants alternate 01,10,01,10.
REQ-040 Stray ack: mem_ack_i=1 while IDLE -> m0_ack_o=m1_ack_o=0, state remains IDLE.
REQ-041 Reset mid-GNT1: rst_i pulled low while grant_o=10 and mem_write_o=1 -> mem_enable_o=mem_write_o=0 and grant_o=00 before the next edge; with both masters requesting after reset release, master 0 is granted first.
